// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC and IF/ID registers, drives the next-PC mux select, and applies stalls and squashes.
// Optional macro FETCH_DELAY_SLOT_EN: a taken branch/jump keeps its delay-slot instruction instead of squashing it.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             jump,
    input  logic             trap,
    input  logic [31:0]      npc,
    input  logic [31:0]      pc4,
    input  logic [31:0]      inst,
    output logic [31:0]      pc,
    output logic [1:0]       pcsource,
    output logic [31:0]      id_pc4,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_RUN    = 3'd1,
        S_HOLD   = 3'd2,
        S_SQUASH = 3'd3,
        S_SLOT   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_BPC  = 2'b01;
    localparam logic [1:0] SEL_JPC  = 2'b10;
    localparam logic [1:0] SEL_TRAP = 2'b11;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      id_pc4_q;
    logic [31:0]      id_inst_q;
    logic             id_valid_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             accept;
    logic             redirect;
    logic [1:0]       pcsource_d;

    // SLOT is deliberately excluded: a branch sitting in a delay slot is not supported.
    always_comb begin
        accept   = 1'b0;
        redirect = 1'b0;
        if ((state_q == S_RUN || state_q == S_HOLD) && !stall) begin
            accept = 1'b1;
        end
        if (accept && (jump || br_taken)) begin
            redirect = 1'b1;
        end
    end

    always_comb begin
        pcsource_d = SEL_PC4;
        if (trap) begin
            pcsource_d = SEL_TRAP;
        end else if (accept && jump) begin
            pcsource_d = SEL_JPC;
        end else if (accept && br_taken) begin
            pcsource_d = SEL_BPC;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            id_pc4_q    <= 32'h0;
            id_inst_q   <= 32'h0;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q <= S_RUN;
                end
                S_SQUASH: begin
                    pc_q <= npc;
                    if (trap) begin
                        id_pc4_q   <= 32'h0;
                        id_inst_q  <= 32'h0;
                        id_valid_q <= 1'b0;
                        state_q    <= S_SQUASH;
                    end else begin
                        id_pc4_q   <= pc4;
                        id_inst_q  <= inst;
                        id_valid_q <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                default: begin
                    if (trap) begin
                        pc_q       <= npc;
                        id_pc4_q   <= 32'h0;
                        id_inst_q  <= 32'h0;
                        id_valid_q <= 1'b0;
                        state_q    <= S_SQUASH;
                    end else if (stall) begin
                        stall_cnt_q <= stall_cnt_d;
`ifdef FETCH_DELAY_SLOT_EN
                        state_q     <= (state_q == S_SLOT) ? S_SLOT : S_HOLD;
`else
                        state_q     <= S_HOLD;
`endif
                    end else if (redirect) begin
                        pc_q <= npc;
`ifdef FETCH_DELAY_SLOT_EN
                        id_pc4_q   <= pc4;
                        id_inst_q  <= inst;
                        id_valid_q <= 1'b1;
                        state_q    <= S_SLOT;
`else
                        id_pc4_q   <= 32'h0;
                        id_inst_q  <= 32'h0;
                        id_valid_q <= 1'b0;
                        state_q    <= S_SQUASH;
`endif
                    end else begin
                        pc_q       <= npc;
                        id_pc4_q   <= pc4;
                        id_inst_q  <= inst;
                        id_valid_q <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign pcsource     = pcsource_d;
    assign id_pc4       = id_pc4_q;
    assign id_inst      = id_inst_q;
    assign id_valid     = id_valid_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small fetch-datapath model (PC+4, next-PC mux, ROM = {16'hC0DE, addr[15:0]}).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic        jump;
    logic        trap;
    logic [31:0] npc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  pcsource;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [15:0] stall_cycles;
    logic [31:0] bpc;
    logic [31:0] jpc;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .jump(jump), .trap(trap),
        .npc(npc), .pc4(pc4), .inst(inst), .pc(pc), .pcsource(pcsource),
        .id_pc4(id_pc4), .id_inst(id_inst), .id_valid(id_valid), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Fetch datapath model: adder, ROM and the 4:1 next-PC mux.
    assign pc4  = pc + 32'd4;
    assign inst = {16'hC0DE, pc[15:0]};
    always_comb begin
        case (pcsource)
            2'b00:   npc = pc4;
            2'b01:   npc = bpc;
            2'b10:   npc = jpc;
            default: npc = 32'h0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic jp, input logic tr,
                                 input logic [31:0] bpcVal, input logic [31:0] jpcVal);
        stall    = st;
        br_taken = br;
        jump     = jp;
        trap     = tr;
        bpc      = bpcVal;
        jpc      = jpcVal;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic [31:0] ePc, input logic [31:0] ePc4,
                             input logic [31:0] eInst, input logic eValid);
        checkOutput({tag, ".pc"}, pc, ePc);
        checkOutput({tag, ".id_pc4"}, id_pc4, ePc4);
        checkOutput({tag, ".id_inst"}, id_inst, eInst);
        checkOutput({tag, ".id_valid"}, {31'h0, id_valid}, {31'h0, eValid});
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkRegs("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("reset.stall_cycles", {16'h0, stall_cycles}, 32'h0);

        // BOOT: one cycle with everything held, jump not accepted.
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200);
        checkOutput("boot.pcsource", {30'h0, pcsource}, 32'h0);
        tick();
        checkRegs("boot", 32'h0, 32'h0, 32'h0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("run0.pcsource", {30'h0, pcsource}, 32'h0);
        tick();
        checkRegs("run0", 32'h4, 32'h4, 32'hC0DE_0000, 1'b1);
        tick();
        checkRegs("run1", 32'h8, 32'h8, 32'hC0DE_0004, 1'b1);

        // Three stalled cycles at pc=8.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        checkRegs("stall", 32'h8, 32'h8, 32'hC0DE_0004, 1'b1);
        checkOutput("stall.stall_cycles", {16'h0, stall_cycles}, 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkRegs("release", 32'hC, 32'hC, 32'hC0DE_0008, 1'b1);
        tick();
        checkRegs("run2", 32'h10, 32'h10, 32'hC0DE_000C, 1'b1);

        // Taken branch at pc=0x10 to 0x40.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        checkOutput("branch.pcsource", {30'h0, pcsource}, 32'h1);
        tick();
`ifdef FETCH_DELAY_SLOT_EN
        checkRegs("branch", 32'h40, 32'h14, 32'hC0DE_0010, 1'b1);
`else
        checkRegs("branch", 32'h40, 32'h0, 32'h0, 1'b0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkRegs("target", 32'h44, 32'h44, 32'hC0DE_0040, 1'b1);

        // jump+branch under stall are ignored; without stall jump wins.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h100);
        checkOutput("stalljmp.pcsource", {30'h0, pcsource}, 32'h0);
        tick();
        checkOutput("stalljmp.pc", pc, 32'h44);
        checkOutput("stalljmp.stall_cycles", {16'h0, stall_cycles}, 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h100);
        checkOutput("jump.pcsource", {30'h0, pcsource}, 32'h2);
        tick();
`ifdef FETCH_DELAY_SLOT_EN
        checkRegs("jump", 32'h100, 32'h48, 32'hC0DE_0044, 1'b1);
`else
        checkRegs("jump", 32'h100, 32'h0, 32'h0, 1'b0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkRegs("jtarget", 32'h104, 32'h104, 32'hC0DE_0100, 1'b1);

        // Trap overrides stall, counter untouched; branch in following SQUASH ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput("trap.pcsource", {30'h0, pcsource}, 32'h3);
        tick();
        checkRegs("trap", 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("trap.stall_cycles", {16'h0, stall_cycles}, 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
        checkOutput("squash.pcsource", {30'h0, pcsource}, 32'h0);
        tick();
        checkRegs("squash", 32'h4, 32'h4, 32'hC0DE_0000, 1'b1);
        checkOutput("squash.stall_cycles", {16'h0, stall_cycles}, 32'd4);

        // Jump to 0x80, then reset mid-flight with other requests active.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80);
        tick();
        checkOutput("j80.pc", pc, 32'h80);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h40);
        tick();
        checkRegs("midreset", 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("midreset.stall_cycles", {16'h0, stall_cycles}, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkRegs("boot2", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checkRegs("run3", 32'h4, 32'h4, 32'hC0DE_0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller for the instruction-fetch datapath (PC+4 adder, 4:1 next-PC mux, instruction ROM).
- Owns the PC register and the IF/ID pipeline register.
- Drives the fetch stage's pcsource select from branch/jump/trap requests, and applies hazard stalls and control-hazard squashes.
- Sits between the fetch datapath and the decode stage; also exposes a stall-cycle counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the stall_cycles counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall request (load-use); freezes PC and IF/ID.
- br_taken  input  1  decode-stage conditional branch resolved taken.
- jump  input  1  decode-stage unconditional jump.
- trap  input  1  exception/trap request; redirects to mux input 3 (32'h0).
- npc  input  32  next PC from the fetch-stage mux.
- pc4  input  32  PC+4 from the fetch stage.
- inst  input  32  instruction read at the current pc.
- pc  output  32  current PC to the fetch stage.
- pcsource  output  2  next-PC mux select: 00 pc4, 01 bpc, 10 jpc, 11 zero/trap.
- id_pc4  output  32  IF/ID registered PC+4.
- id_inst  output  32  IF/ID registered instruction (32'h0 = bubble/nop).
- id_valid  output  1  IF/ID slot holds a real instruction.
- stall_cycles  output  CNT_W  saturating count of cycles frozen by stall.

Behaviour:
- Reset (rst=1 at edge) sets:
  - pc=RESET_PC, id_pc4=0, id_inst=0, id_valid=0, stall_cycles=0
  - state=BOOT
  - Reset takes effect mid-operation, regardless of any other input.
- pcsource is combinational, with priority trap > jump > br_taken:
  - 11 if trap.
  - 10 if jump and request is accepted.
  - 01 if br_taken and request is accepted.
  - Else 00.
  - jump and br_taken together select 10.
- Request acceptance: jump/br_taken are accepted only in state RUN or HOLD with stall=0; otherwise they are ignored and pcsource=00 (unless trap).
- State BOOT:
  - Lasts exactly 1 cycle after reset release.
  - pc, IF/ID and counter hold; id_valid=0.
  - Next state RUN; trap is ignored in BOOT.
- State RUN / HOLD, evaluated in this order:
  - trap=1: pc<=npc (32'h0); IF/ID<=bubble (id_inst=0, id_valid=0, id_pc4=0); next SQUASH. Overrides stall.
  - stall=1: pc, id_pc4, id_inst, id_valid hold; stall_cycles+=1, saturating at all-ones; next HOLD.
  - Accepted redirect: pc<=npc; IF/ID<=bubble; next SQUASH. The wrong-path instruction fetched this cycle is discarded.
  - Otherwise: pc<=npc (=pc4); id_pc4<=pc4; id_inst<=inst; id_valid<=1; next RUN.
- State SQUASH (ID holds a bubble):
  - stall, br_taken and jump are ignored.
  - pc<=npc; IF/ID loads pc4/inst with id_valid=1; next RUN.
  - trap in SQUASH follows the trap rule: bubble again, stay SQUASH.
- Latency:
  - Redirect accepted in cycle N → target instruction in IF at N+1 → in ID (id_valid=1) at N+2.
  - One-cycle penalty per taken branch/jump.
- Width rules:
  - PC arithmetic is done by the datapath; this block stores npc unmodified.
  - No alignment check.
- Counter: increments only on cycles where stall freezes the pipe (RUN/HOLD, no trap); never wraps.

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- Defined:
  - An accepted br_taken/jump loads IF/ID with the delay-slot instruction (pc4/inst, id_valid=1) instead of a bubble.
  - Next state is SLOT.
  - SLOT behaves as RUN, except br_taken/jump are ignored (branch in delay slot unsupported); stall is honoured (stay SLOT while stalled); next RUN.
  - Trap still squashes (bubble, SQUASH).
  - Redirect penalty is 0 cycles.
- Undefined: behaviour as above; state SLOT does not exist.

Test Plan:
- Reset with RESET_PC=0, run 4 cycles, no requests → cycle 1 BOOT id_valid=0; then pc steps 0,4,8,…; id_inst tracks ROM words; pcsource=00.
- stall=1 for 3 cycles at pc=8 → pc stays 8, IF/ID frozen, stall_cycles=3; on release pc advances to 12.
- br_taken=1 with bpc=0x40 at pc=0x10 → pcsource=01, pc=0x40 next cycle, id_valid=0 for one cycle, then id_inst=ROM[0x40>>2] with id_valid=1. With FETCH_DELAY_SLOT_EN, id_inst=ROM[0x10>>2] with id_valid=1 instead.
- jump=1 and br_taken=1 together with stall=1 → ignored, pcsource=00, pc held. Repeat with stall=0 → pcsource=10, pc=jpc.
- trap=1 while stall=1 → pcsource=11, pc=0, bubble in ID, stall_cycles unchanged. br_taken in the following SQUASH cycle is ignored.
- rst asserted mid-SQUASH with pc=0x80 → next cycle pc=RESET_PC, id_valid=0, stall_cycles=0, state BOOT.
